decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction decode stage with valid/ready handshake on both sides.
- Sits between the fetch stage and the register-file read/execute stage.
- Produces ALU control, writeback control, sign-extended immediate, register indices, branch/illegal flags and the passed-through PC.
- Optional 2-entry skid buffer breaks the ready path; a flush input supports branch redirect.

Parameters:
- XLEN, 32, datapath width (32 or 64); the immediate is sign-extended to XLEN.
- PC_W, 32, width of the PC passed through with each instruction.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single stage with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held instructions.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts.
- out_pc  out  PC_W  PC of the decoded instruction.
- alucontrol  out  4  ALU/branch operation code.
- reg_write  out  1  write rd.
- mem_write  out  1  store.
- result_src  out  2  00 ALU, 01 load data, 10 PC+4, 11 immediate.
- alu_src_imm  out  1  ALU operand B = immediate.
- imm  out  XLEN  sign-extended immediate.
- rd, rs1, rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20]).
- is_branch  out  1  B-type instruction.
- is_jump  out  1  JAL/JALR.
- illegal  out  1  unsupported opcode.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, skid entry empty, all decoded outputs 0, in_ready=1 (SKID=1) on the following cycle.
- Latency: 1 cycle. An instruction accepted at edge N (in_valid && in_ready) appears with out_valid=1 after edge N.
- Transfer out: occurs on an edge with out_valid && out_ready. Outputs are held stable while out_valid && !out_ready.
- SKID=1:
  - Output register plus one skid entry.
  - Accept while output is stalled goes to the skid entry; in_ready is registered and equals !skid_full.
  - On drain, skid contents move to the output register. Order is strictly preserved.
  - Accept and drain on the same edge are legal at every occupancy.
- SKID=0: in_ready = !out_valid || out_ready, combinational.
- Flush: out_valid=0 and skid cleared at the next edge. An instruction presented in the flush cycle is dropped. flush has priority over accept; rst has priority over flush.
- Decode by opcode instr[6:0]:
  - 0110011 R: reg_write=1, alu_src_imm=0, result_src=00.
  - 0010011 I-ALU: reg_write=1, alu_src_imm=1, imm=I.
  - 0000011 load: reg_write=1, result_src=01, alucontrol=ADD, imm=I.
  - 0100011 store: mem_write=1, alucontrol=ADD, imm=S.
  - 1100011 branch: is_branch=1, imm=B.
  - 1101111 JAL: reg_write=1, result_src=10, is_jump=1, imm=J.
  - 1100111 JALR: as JAL, alu_src_imm=1, imm=I.
  - 0110111 LUI: reg_write=1, result_src=11, imm=U.
  - 0010111 AUIPC: reg_write=1, alucontrol=ADD, alu_src_imm=1, imm=U.
  - Any other opcode: illegal=1; reg_write, mem_write, is_branch and is_jump forced 0; alucontrol=0.
- ALU codes for R and I-ALU (by funct3):
  - 000: ADD=0, or SUB=1 only for R-type with instr[30]=1; ADDI ignores instr[30].
  - 111: AND=2. 110: OR=3. 100: XOR=4. 001: SLL=5.
  - 101: SRL=6, or SRA=7 when instr[30]=1.
  - 011: SLTU=8. 010: SLT=9.
- Branch codes (by funct3): 000 BEQ=0, 001 BNE=1, 100 BLT=2, 101 BGE=3, 110 BLTU=4, 111 BGEU=5. funct3 010 or 011 on a branch sets illegal=1.
- Every output is fully assigned for every input; no latches.
- Immediates are sign-extended from bit 31 to XLEN. U-type low 12 bits are 0. B and J immediates have bit0=0.
- When XLEN=64, I-ALU shift amount uses instr[25:20].

Test Plan:
- rst, then in 0x00500093 (ADDI x1,x0,5) -> next cycle: out_valid=1, alucontrol=0, imm=5, rd=1, reg_write=1, alu_src_imm=1, illegal=0.
- 0x402081B3 (SUB x3,x1,x2) -> alucontrol=1, rd=3, rs1=1, rs2=2. Then 0x40508093 (ADDI, bit30=1) -> alucontrol=0.
- 0xFE209CE3 (BNE x1,x2,-8) -> is_branch=1, alucontrol=1, imm=0xFFFFFFF8, reg_write=0.
- 0x123452B7 (LUI x5) -> imm=0x12345000, result_src=11. 0xFFFFFFFF -> illegal=1, reg_write=0, mem_write=0.
- SKID=1, out_ready=0, push A, B, C back-to-back -> A in output, B in skid, in_ready=0 and C held. Raise out_ready -> A, B, C delivered in order, no loss or duplicate.
- With two entries held, pulse flush for 1 cycle -> out_valid=0 next cycle, in_ready=1, and the next accepted instruction is the first one output.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake bundle around the decode stage: fetch-side request, decoded-bundle response and flush.
// The master modport is the environment (fetch plus consumer); the slave modport is the stage.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [3:0]      alucontrol;
  logic            reg_write;
  logic            mem_write;
  logic [1:0]      result_src;
  logic            alu_src_imm;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            is_branch;
  logic            is_jump;
  logic            illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, alucontrol, reg_write, mem_write,
           result_src, alu_src_imm, imm, rd, rs1, rs2, is_branch, is_jump, illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, alucontrol, reg_write, mem_write,
           result_src, alu_src_imm, imm, rd, rs1, rs2, is_branch, is_jump, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready on both sides, optional skid entry and flush.
// Instructions are decoded combinationally on entry; the output register and skid entry hold decoded bundles.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      alucontrol;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            alu_src_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;
  } dec_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic b30, input logic is_r);
    logic [3:0] c;
    case (f3)
      3'b000:  c = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b111:  c = ALU_AND;
      3'b110:  c = ALU_OR;
      3'b100:  c = ALU_XOR;
      3'b001:  c = ALU_SLL;
      3'b101:  c = b30 ? ALU_SRA : ALU_SRL;
      3'b011:  c = ALU_SLTU;
      default: c = ALU_SLT;
    endcase
    return c;
  endfunction

  function automatic dec_t decode(input logic [31:0] i, input logic [PC_W-1:0] pc);
    dec_t                   d;
    logic [2:0]             f3;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [XLEN-1:0]        shamt;
    f3    = i[14:12];
    imm_i = sext32({{20{i[31]}}, i[31:20]});
    imm_s = sext32({{20{i[31]}}, i[31:25], i[11:7]});
    imm_b = sext32({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
    imm_j = sext32({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
    imm_u = sext32({i[31:12], 12'b0});
    // Shift-immediates carry only the shift amount; RV64 widens it to six bits.
    shamt = '0;
    if (XLEN == 64) shamt[5:0] = i[25:20];
    else            shamt[4:0] = i[24:20];
    d     = '0;
    d.pc  = pc;
    d.rd  = i[11:7];
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    case (i[6:0])
      OP_R: begin
        d.reg_write  = 1'b1;
        d.alucontrol = alu_code(f3, i[30], 1'b1);
      end
      OP_I: begin
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
        d.alucontrol  = alu_code(f3, i[30], 1'b0);
        d.imm         = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
      end
      OP_LOAD: begin
        d.reg_write   = 1'b1;
        d.result_src  = 2'b01;
        d.alu_src_imm = 1'b1;
        d.imm         = imm_i;
      end
      OP_STORE: begin
        d.mem_write   = 1'b1;
        d.alu_src_imm = 1'b1;
        d.imm         = imm_s;
      end
      OP_BRANCH: begin
        d.imm = imm_b;
        case (f3)
          3'b000:  d.alucontrol = 4'd0;
          3'b001:  d.alucontrol = 4'd1;
          3'b100:  d.alucontrol = 4'd2;
          3'b101:  d.alucontrol = 4'd3;
          3'b110:  d.alucontrol = 4'd4;
          3'b111:  d.alucontrol = 4'd5;
          default: d.illegal    = 1'b1;
        endcase
        d.is_branch = !d.illegal;
      end
      OP_JAL: begin
        d.reg_write  = 1'b1;
        d.result_src = 2'b10;
        d.is_jump    = 1'b1;
        d.imm        = imm_j;
      end
      OP_JALR: begin
        d.reg_write   = 1'b1;
        d.result_src  = 2'b10;
        d.is_jump     = 1'b1;
        d.alu_src_imm = 1'b1;
        d.imm         = imm_i;
      end
      OP_LUI: begin
        d.reg_write  = 1'b1;
        d.result_src = 2'b11;
        d.imm        = imm_u;
      end
      OP_AUIPC: begin
        d.reg_write   = 1'b1;
        d.alu_src_imm = 1'b1;
        d.imm         = imm_u;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  dec_t in_dec;
  dec_t out_d, out_q;
  dec_t skid_d, skid_q;
  logic out_vld_d, out_vld_q;
  logic skid_vld_d, skid_vld_q;
  logic in_ready_d, in_ready_q;
  logic in_ready;
  logic accept;

  assign in_dec   = decode(bus.in_instr, bus.in_pc);
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_vld_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || bus.out_ready) begin
      // Output slot frees this edge: the older skid entry goes first to keep order.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = in_dec;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = in_dec;
      end
    end else if (accept && SKID != 0) begin
      skid_d     = in_dec;
      skid_vld_d = 1'b1;
    end
    in_ready_d = !skid_vld_d;
  end

  // Stage boundary: output register and skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.alucontrol  = out_q.alucontrol;
  assign bus.reg_write   = out_q.reg_write;
  assign bus.mem_write   = out_q.mem_write;
  assign bus.result_src  = out_q.result_src;
  assign bus.alu_src_imm = out_q.alu_src_imm;
  assign bus.imm         = out_q.imm;
  assign bus.rd          = out_q.rd;
  assign bus.rs1         = out_q.rs1;
  assign bus.rs2         = out_q.rs2;
  assign bus.is_branch   = out_q.is_branch;
  assign bus.is_jump     = out_q.is_jump;
  assign bus.illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid ordering under stall, and flush behaviour.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

  decode_stage #(.XLEN(32), .PC_W(32), .SKID(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    int t;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for pc 0x%0h", pc);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] got[$];
  logic [31:0] exp_pc[3];
  logic        acc;

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_imm", bus.imm, 0);
    check_eq("rst_reg_write", bus.reg_write, 0);

    bus.out_ready = 1'b1;
    push(32'h00500093, 32'h100);  // ADDI x1,x0,5
    check_eq("addi_valid", bus.out_valid, 1);
    check_eq("addi_alu", bus.alucontrol, 0);
    check_eq("addi_imm", bus.imm, 5);
    check_eq("addi_rd", bus.rd, 1);
    check_eq("addi_rw", bus.reg_write, 1);
    check_eq("addi_srcimm", bus.alu_src_imm, 1);
    check_eq("addi_illegal", bus.illegal, 0);
    check_eq("addi_pc", bus.out_pc, 32'h100);

    push(32'h402081B3, 32'h104);  // SUB x3,x1,x2
    check_eq("sub_alu", bus.alucontrol, 1);
    check_eq("sub_rd", bus.rd, 3);
    check_eq("sub_rs1", bus.rs1, 1);
    check_eq("sub_rs2", bus.rs2, 2);
    check_eq("sub_srcimm", bus.alu_src_imm, 0);

    push(32'h40508093, 32'h108);  // ADDI with bit30 set
    check_eq("addi30_alu", bus.alucontrol, 0);
    check_eq("addi30_imm", bus.imm, 32'h405);

    push(32'hFE209CE3, 32'h10C);  // BNE x1,x2,-8
    check_eq("bne_branch", bus.is_branch, 1);
    check_eq("bne_alu", bus.alucontrol, 1);
    check_eq("bne_imm", bus.imm, 32'hFFFFFFF8);
    check_eq("bne_rw", bus.reg_write, 0);

    push(32'h123452B7, 32'h110);  // LUI x5
    check_eq("lui_imm", bus.imm, 32'h12345000);
    check_eq("lui_rsrc", bus.result_src, 2'b11);
    check_eq("lui_rd", bus.rd, 5);

    push(32'hFFFFFFFF, 32'h114);
    check_eq("ill_flag", bus.illegal, 1);
    check_eq("ill_rw", bus.reg_write, 0);
    check_eq("ill_mw", bus.mem_write, 0);
    check_eq("ill_alu", bus.alucontrol, 0);

    push(32'h0020A423, 32'h118);  // SW x2,8(x1)
    check_eq("sw_mw", bus.mem_write, 1);
    check_eq("sw_imm", bus.imm, 8);
    check_eq("sw_rw", bus.reg_write, 0);

    push(32'h008000EF, 32'h11C);  // JAL x1,8
    check_eq("jal_jump", bus.is_jump, 1);
    check_eq("jal_imm", bus.imm, 8);
    check_eq("jal_rsrc", bus.result_src, 2'b10);

    push(32'h4030D093, 32'h120);  // SRAI x1,x1,3
    check_eq("srai_alu", bus.alucontrol, 7);

    push(32'h0020A063, 32'h124);  // branch funct3=010
    check_eq("br010_illegal", bus.illegal, 1);
    step();
    check_eq("drained_valid", bus.out_valid, 0);

    // Skid: stall output, push A, B, C back to back.
    bus.out_ready = 1'b0;
    bus.in_instr  = 32'h00500093;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h200;
    step();
    bus.in_pc = 32'h204;
    step();
    check_eq("skid_hold_pc", bus.out_pc, 32'h200);
    check_eq("skid_full_rdy", bus.in_ready, 0);
    bus.in_pc = 32'h208;
    step();
    check_eq("skid_c_wait_valid", bus.out_valid, 1);
    check_eq("skid_c_wait_pc", bus.out_pc, 32'h200);
    check_eq("skid_c_wait_rdy", bus.in_ready, 0);

    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_pc);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    exp_pc[0] = 32'h200;
    exp_pc[1] = 32'h204;
    exp_pc[2] = 32'h208;
    check_eq("skid_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("skid_order%0d", k), (k < got.size()) ? got[k] : 32'hDEADBEEF, exp_pc[k]);

    // Flush with two entries held.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h300;
    step();
    bus.in_pc = 32'h304;
    step();
    bus.in_valid = 1'b0;
    check_eq("pre_flush_valid", bus.out_valid, 1);
    check_eq("pre_flush_rdy", bus.in_ready, 0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h308;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_valid", bus.out_valid, 0);
    check_eq("flush_rdy", bus.in_ready, 1);

    // Flush with an empty stage and a ready input: the presented instruction is dropped.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h30C;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_drop_valid", bus.out_valid, 0);

    bus.out_ready = 1'b1;
    push(32'h00500093, 32'h310);
    check_eq("post_flush_valid", bus.out_valid, 1);
    check_eq("post_flush_pc", bus.out_pc, 32'h310);
    step();
    check_eq("post_flush_empty", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
